noc_flit_injector: RTL and testbench

- Synthesizable, parametrised packet source for one router input port.
- Accepts a packet command (dst, src, VC, length, payload seed) and serialises it into HEAD / DATA... / TAIL flits on the router's per-VC ack/lock handshake.
- Used as the local-port traffic generator in mesh self-test and as the reusable stimulus engine for router benches.
- Supports N virtual channels, variable packet length, and an optional automatic free-VC selection mode.

---
 rtl/noc_flit_injector_pkg.sv | 29 ++
 rtl/noc_vc_pick.sv | 24 ++
 rtl/noc_flit_injector.sv | 196 +++++++++++++++++++
 tb/tb_noc_flit_injector.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_injector_pkg.sv
// Shared flit definitions for the NoC packet injector and router-side helpers.
// Field offsets assume the default field widths; flit_width() serves other sizings.
package noc_flit_injector_pkg;

    localparam int unsigned TYPE_HEAD     = 1;
    localparam int unsigned TYPE_DATA     = 2;
    localparam int unsigned TYPE_TAIL     = 3;
    localparam int unsigned TYPE_HEADTAIL = 4;

    localparam int unsigned DEF_DSTW  = 4;
    localparam int unsigned DEF_SRCW  = 4;
    localparam int unsigned DEF_VCW   = 2;
    localparam int unsigned DEF_SPECW = 22;
    localparam int unsigned DEF_TYPEW = 3;

    localparam int unsigned DST_LSB  = 0;
    localparam int unsigned SRC_LSB  = DST_LSB + DEF_DSTW;
    localparam int unsigned VCH_LSB  = SRC_LSB + DEF_SRCW;
    localparam int unsigned SPEC_LSB = VCH_LSB + DEF_VCW;
    localparam int unsigned TYPE_LSB = SPEC_LSB + DEF_SPECW;
    localparam int unsigned FLIT_W   = TYPE_LSB + DEF_TYPEW;

    function automatic int unsigned flit_width(input int unsigned dstw, input int unsigned srcw,
                                               input int unsigned vcw, input int unsigned specw,
                                               input int unsigned typew);
        return dstw + srcw + vcw + specw + typew;
    endfunction

endpackage

// File: rtl/noc_vc_pick.sv
// Combinational lowest-index selector over a per-VC eligibility vector.
// Shared between the flit injector and router VC allocation.
module noc_vc_pick #(
    parameter int unsigned NVC  = 2,
    parameter int unsigned IDXW = 2
) (
    input  logic [NVC-1:0]  req,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = int'(NVC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/noc_flit_injector.sv
// Packet source for one router input port: serialises a command into HEAD/DATA/TAIL
// flits on the per-VC ack/lock handshake, with optional automatic VC selection.
module noc_flit_injector
    import noc_flit_injector_pkg::*;
#(
    parameter int unsigned DSTW    = 4,
    parameter int unsigned SRCW    = 4,
    parameter int unsigned NVC     = 2,
    parameter int unsigned VCW     = 2,
    parameter int unsigned SPECW   = 22,
    parameter int unsigned TYPEW   = 3,
    parameter int unsigned LENW    = 4,
    parameter int unsigned VC_AUTO = 0,
    parameter int unsigned CNTW    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [DSTW-1:0]                       cmd_dst,
    input  logic [SRCW-1:0]                       cmd_src,
    input  logic [VCW-1:0]                        cmd_vch,
    input  logic [LENW-1:0]                       cmd_len,
    input  logic [SPECW-1:0]                      cmd_spec,
    output logic [TYPEW+SPECW+VCW+SRCW+DSTW-1:0]  odata,
    output logic                                  ovalid,
    output logic [VCW-1:0]                        ovch,
    input  logic [NVC-1:0]                        iack,
    input  logic [NVC-1:0]                        ilck,
    output logic                                  busy,
    output logic [CNTW-1:0]                       pkt_cnt,
    output logic [CNTW-1:0]                       flit_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DSTW-1:0]  dst_q, dst_d;
    logic [SRCW-1:0]  src_q, src_d;
    logic [VCW-1:0]   vch_q, vch_d;
    logic [LENW-1:0]  rem_q, rem_d;
    logic [LENW-1:0]  idx_q, idx_d;
    logic [SPECW-1:0] seed_q, seed_d;
    logic [CNTW-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNTW-1:0]  flit_cnt_q, flit_cnt_d;

    logic [NVC-1:0]   elig;
    logic             pick_any;
    logic [VCW-1:0]   pick_idx;
    logic [VCW-1:0]   cur_vch;
    logic [VCW-1:0]   cmd_vch_ok;
    logic             ack_sel;
    logic             lck_sel;
    logic             last_flit;
    logic             xfer;
    logic [TYPEW-1:0] ftype;
    logic [SPECW-1:0] fspec;

    assign elig = iack & ~ilck;

    noc_vc_pick #(
        .NVC  (NVC),
        .IDXW (VCW)
    ) u_vc_pick (
        .req (elig),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Auto mode follows the live pick during HEAD; the choice is frozen on head transfer.
    always_comb begin
        cur_vch = vch_q;
        if (VC_AUTO != 0 && state_q == ST_HEAD) begin
            cur_vch = pick_idx;
        end
        ack_sel = 1'b0;
        lck_sel = 1'b0;
        for (int v = 0; v < int'(NVC); v++) begin
            if (VCW'(v) == cur_vch) begin
                ack_sel = iack[v];
                lck_sel = ilck[v];
            end
        end

        last_flit = 1'b0;
        ftype     = '0;
        fspec     = '0;
        ovalid    = 1'b0;
        case (state_q)
            ST_HEAD: begin
                last_flit = (rem_q == LENW'(1));
                ftype     = last_flit ? TYPEW'(TYPE_HEADTAIL) : TYPEW'(TYPE_HEAD);
                fspec     = seed_q;
                ovalid    = (VC_AUTO != 0) ? pick_any : (ack_sel & ~lck_sel);
            end
            ST_BODY: begin
                last_flit = (idx_q == rem_q - LENW'(1));
                ftype     = last_flit ? TYPEW'(TYPE_TAIL) : TYPEW'(TYPE_DATA);
                fspec     = seed_q + SPECW'(idx_q);
                ovalid    = 1'b1;
            end
            default: ;
        endcase

        xfer      = ovalid & ack_sel;
        busy      = (state_q != ST_IDLE);
        cmd_ready = (state_q == ST_IDLE);
        odata     = '0;
        ovch      = '0;
        if (busy) begin
            odata = {ftype, fspec, cur_vch, src_q, dst_q};
            ovch  = cur_vch;
        end
    end

    assign cmd_vch_ok = (32'(cmd_vch) < NVC) ? cmd_vch : '0;

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        src_d      = src_q;
        vch_d      = vch_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        seed_d     = seed_q;
        pkt_cnt_d  = pkt_cnt_q;
        flit_cnt_d = flit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    seed_d  = cmd_spec;
                    vch_d   = cmd_vch_ok;
                    rem_d   = (cmd_len == '0) ? LENW'(1) : cmd_len;
                    idx_d   = '0;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (xfer) begin
                    vch_d   = cur_vch;
                    idx_d   = LENW'(1);
                    state_d = last_flit ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    idx_d = idx_q + LENW'(1);
                    if (last_flit) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            flit_cnt_d = flit_cnt_q + CNTW'(1);
            if (last_flit) begin
                pkt_cnt_d = pkt_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            src_q      <= '0;
            vch_q      <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            seed_q     <= '0;
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            vch_q      <= vch_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            seed_q     <= seed_d;
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_noc_flit_injector.sv
// Self-checking bench: one fixed-VC and one auto-VC injector share stimulus and are
// checked every cycle against a packet-level model, plus literal directed expectations.
module tb_noc_flit_injector;
    import noc_flit_injector_pkg::*;

    localparam int FW = FLIT_W;
    localparam logic [2:0] T_HEAD = 3'(TYPE_HEAD);
    localparam logic [2:0] T_DATA = 3'(TYPE_DATA);
    localparam logic [2:0] T_TAIL = 3'(TYPE_TAIL);
    localparam logic [2:0] T_HT   = 3'(TYPE_HEADTAIL);

    logic        clk = 1'b0;
    logic        rst_;
    logic        cmd_valid;
    logic [3:0]  cmd_dst, cmd_src, cmd_len;
    logic [1:0]  cmd_vch;
    logic [21:0] cmd_spec;
    logic [1:0]  iack, ilck;

    logic          cmd_ready [2];
    logic [FW-1:0] odata     [2];
    logic          ovalid    [2];
    logic [1:0]    ovch      [2];
    logic          busy      [2];
    logic [15:0]   pkt_cnt   [2];
    logic [15:0]   flit_cnt  [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_flit_injector #(.VC_AUTO(0)) dut0 (
        .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_vch(cmd_vch), .cmd_len(cmd_len),
        .cmd_spec(cmd_spec), .odata(odata[0]), .ovalid(ovalid[0]), .ovch(ovch[0]),
        .iack(iack), .ilck(ilck), .busy(busy[0]), .pkt_cnt(pkt_cnt[0]),
        .flit_cnt(flit_cnt[0])
    );

    noc_flit_injector #(.VC_AUTO(1)) dut1 (
        .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_vch(cmd_vch), .cmd_len(cmd_len),
        .cmd_spec(cmd_spec), .odata(odata[1]), .ovalid(ovalid[1]), .ovch(ovch[1]),
        .iack(iack), .ilck(ilck), .busy(busy[1]), .pkt_cnt(pkt_cnt[1]),
        .flit_cnt(flit_cnt[1])
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] pack(input logic [2:0] t, input logic [21:0] s,
                                           input logic [1:0] v, input logic [3:0] sr,
                                           input logic [3:0] d);
        logic [FW-1:0] r;
        r = '0;
        r[TYPE_LSB +: 3]  = t;
        r[SPEC_LSB +: 22] = s;
        r[VCH_LSB +: 2]   = v;
        r[SRC_LSB +: 4]   = sr;
        r[DST_LSB +: 4]   = d;
        return r;
    endfunction

    // Packet model: each accepted command becomes a precomputed list of flits.
    bit          m_act  [2];
    int          m_pos  [2];
    int          m_n    [2];
    logic [1:0]  m_vc   [2];
    logic [3:0]  m_dst  [2];
    logic [3:0]  m_src  [2];
    logic [2:0]  m_typ  [2][16];
    logic [21:0] m_spec [2][16];
    logic [15:0] m_pkt  [2];
    logic [15:0] m_flit [2];

    logic [FW-1:0] log0[$];
    logic [1:0]    log1_vc[$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit         ev;
            bit         xf;
            logic [1:0] vc;
            if (rst_) begin
                chk($sformatf("rst.ovalid%0d", k), 64'(ovalid[k]), 64'd0);
                chk($sformatf("rst.odata%0d", k), 64'(odata[k]), 64'd0);
                chk($sformatf("rst.ovch%0d", k), 64'(ovch[k]), 64'd0);
                chk($sformatf("rst.ready%0d", k), 64'(cmd_ready[k]), 64'd1);
                chk($sformatf("rst.busy%0d", k), 64'(busy[k]), 64'd0);
                chk($sformatf("rst.pkt%0d", k), 64'(pkt_cnt[k]), 64'd0);
                chk($sformatf("rst.flit%0d", k), 64'(flit_cnt[k]), 64'd0);
                m_act[k]  = 0;
                m_pkt[k]  = '0;
                m_flit[k] = '0;
            end else begin
                chk($sformatf("pkt_cnt%0d", k), 64'(pkt_cnt[k]), 64'(m_pkt[k]));
                chk($sformatf("flit_cnt%0d", k), 64'(flit_cnt[k]), 64'(m_flit[k]));
                if (!m_act[k]) begin
                    chk($sformatf("idle.ready%0d", k), 64'(cmd_ready[k]), 64'd1);
                    chk($sformatf("idle.busy%0d", k), 64'(busy[k]), 64'd0);
                    chk($sformatf("idle.ovalid%0d", k), 64'(ovalid[k]), 64'd0);
                    chk($sformatf("idle.odata%0d", k), 64'(odata[k]), 64'd0);
                    chk($sformatf("idle.ovch%0d", k), 64'(ovch[k]), 64'd0);
                    if (cmd_valid) begin
                        m_act[k] = 1;
                        m_pos[k] = 0;
                        m_n[k]   = (cmd_len == 0) ? 1 : int'(cmd_len);
                        m_dst[k] = cmd_dst;
                        m_src[k] = cmd_src;
                        m_vc[k]  = (cmd_vch < 2'd2) ? cmd_vch : 2'd0;
                        for (int i = 0; i < m_n[k]; i++) begin
                            if (m_n[k] == 1)          m_typ[k][i] = T_HT;
                            else if (i == 0)          m_typ[k][i] = T_HEAD;
                            else if (i == m_n[k] - 1) m_typ[k][i] = T_TAIL;
                            else                      m_typ[k][i] = T_DATA;
                            m_spec[k][i] = cmd_spec + 22'(i);
                        end
                    end
                end else begin
                    chk($sformatf("pkt.ready%0d", k), 64'(cmd_ready[k]), 64'd0);
                    chk($sformatf("pkt.busy%0d", k), 64'(busy[k]), 64'd1);
                    if (m_pos[k] == 0) begin
                        if (k == 1) begin
                            ev = 0;
                            vc = 2'd0;
                            for (int v = 1; v >= 0; v--) begin
                                if (iack[v] && !ilck[v]) begin
                                    ev = 1;
                                    vc = 2'(v);
                                end
                            end
                        end else begin
                            vc = m_vc[k];
                            ev = iack[vc] && !ilck[vc];
                        end
                        chk($sformatf("head.ovalid%0d", k), 64'(ovalid[k]), 64'(ev));
                        if (ev) begin
                            chk($sformatf("head.odata%0d", k), 64'(odata[k]),
                                64'(pack(m_typ[k][0], m_spec[k][0], vc, m_src[k], m_dst[k])));
                            chk($sformatf("head.ovch%0d", k), 64'(ovch[k]), 64'(vc));
                            m_vc[k] = vc;
                        end
                        xf = ev;
                    end else begin
                        chk($sformatf("body.ovalid%0d", k), 64'(ovalid[k]), 64'd1);
                        chk($sformatf("body.ovch%0d", k), 64'(ovch[k]), 64'(m_vc[k]));
                        chk($sformatf("body.odata%0d", k), 64'(odata[k]),
                            64'(pack(m_typ[k][m_pos[k]], m_spec[k][m_pos[k]], m_vc[k],
                                     m_src[k], m_dst[k])));
                        xf = iack[m_vc[k]];
                    end
                    if (xf) begin
                        if (k == 0) log0.push_back(odata[0]);
                        else        log1_vc.push_back(ovch[1]);
                        m_flit[k] = m_flit[k] + 16'd1;
                        if (m_typ[k][m_pos[k]] == T_TAIL || m_typ[k][m_pos[k]] == T_HT)
                            m_pkt[k] = m_pkt[k] + 16'd1;
                        m_pos[k]++;
                        if (m_pos[k] == m_n[k]) m_act[k] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while ((m_act[0] || m_act[1]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle.timeout", 64'(m_act[0] || m_act[1]), 64'd0);
    endtask

    task automatic wait_log0(input int n);
        int c = 0;
        while (log0.size() < n && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        chk("wait_log0.timeout", 64'(log0.size() < n), 64'd0);
    endtask

    task automatic wait_log1(input int n);
        int c = 0;
        while (log1_vc.size() < n && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        chk("wait_log1.timeout", 64'(log1_vc.size() < n), 64'd0);
    endtask

    task automatic send(input logic [3:0] d, input logic [3:0] s, input logic [1:0] v,
                        input logic [3:0] l, input logic [21:0] sp);
        wait_idle();
        cmd_dst   = d;
        cmd_src   = s;
        cmd_vch   = v;
        cmd_len   = l;
        cmd_spec  = sp;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        logic [FW-1:0] f;
        rst_ = 1'b1; cmd_valid = 1'b0; cmd_dst = '0; cmd_src = '0; cmd_vch = '0;
        cmd_len = '0; cmd_spec = '0; iack = 2'b11; ilck = 2'b00;
        @(negedge clk);
        chk("reset.ready_lit", 64'(cmd_ready[0]), 64'd1);
        chk("reset.ovalid_lit", 64'(ovalid[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b0;

        // Three-flit packet on VC0
        b = log0.size();
        send(4'b0110, 4'h1, 2'd0, 4'd3, 22'h0b);
        wait_log0(b + 3);
        @(negedge clk);
        chk("t1.ready_after_tail", 64'(cmd_ready[0]), 64'd1);
        chk("t1.pkt_cnt", 64'(pkt_cnt[0]), 64'd1);
        chk("t1.flit_cnt", 64'(flit_cnt[0]), 64'd3);
        chk("t1.head", 64'(log0[b]), 64'h1_0000_2C16);
        chk("t1.data", 64'(log0[b + 1]), 64'h2_0000_3016);
        chk("t1.tail", 64'(log0[b + 2]), 64'h3_0000_3416);

        // Zero length becomes a single HEADTAIL
        b = log0.size();
        send(4'h3, 4'h2, 2'd0, 4'd0, 22'h20);
        wait_log0(b + 1);
        @(negedge clk);
        chk("t2.headtail", 64'(log0[b]), 64'h4_0000_8023);
        chk("t2.pkt_cnt", 64'(pkt_cnt[0]), 64'd2);
        chk("t2.busy", 64'(busy[0]), 64'd0);

        // Five-cycle stall on the second flit
        b = log0.size();
        send(4'b0110, 4'h1, 2'd0, 4'd4, 22'h100);
        wait_log0(b + 1);
        iack = 2'b10;
        repeat (5) begin
            @(negedge clk);
            chk("t3.stall_ovalid", 64'(ovalid[0]), 64'd1);
            chk("t3.stall_odata", 64'(odata[0]), 64'h2_0004_0416);
        end
        @(posedge clk); #1;
        iack = 2'b11;
        wait_log0(b + 4);
        @(negedge clk);
        chk("t3.data1", 64'(log0[b + 1]), 64'h2_0004_0416);
        chk("t3.tail", 64'(log0[b + 3]), 64'h3_0004_0C16);
        chk("t3.flit_cnt", 64'(flit_cnt[0]), 64'd8);

        // Auto VC avoids locked VC0; body ignores a later lock on VC1
        ilck = 2'b01;
        b = log1_vc.size();
        send(4'h5, 4'h2, 2'd0, 4'd3, 22'h40);
        wait_log1(b + 1);
        chk("t4.head_vc", 64'(log1_vc[b]), 64'd1);
        ilck = 2'b11;
        @(negedge clk);
        chk("t4.fixed_locked", 64'(ovalid[0]), 64'd0);
        chk("t4.auto_body", 64'(ovalid[1]), 64'd1);
        wait_log1(b + 3);
        chk("t4.tail_vc", 64'(log1_vc[b + 2]), 64'd1);
        ilck = 2'b00;
        wait_idle();

        // Fixed VC1 held off by its lock for three cycles
        ilck = 2'b10;
        send(4'h9, 4'h3, 2'd1, 4'd2, 22'h7);
        repeat (3) begin
            @(negedge clk);
            chk("t5.locked_ovalid", 64'(ovalid[0]), 64'd0);
        end
        @(posedge clk); #1;
        ilck = 2'b00;
        @(negedge clk);
        chk("t5.head_ovalid", 64'(ovalid[0]), 64'd1);
        chk("t5.head_ovch", 64'(ovch[0]), 64'd1);
        wait_idle();

        // Reset in the middle of a body
        b = log0.size();
        send(4'h2, 4'h4, 2'd0, 4'd5, 22'h3FFFFE);
        wait_log0(b + 2);
        rst_ = 1'b1;
        @(negedge clk);
        chk("t6.ovalid", 64'(ovalid[0]), 64'd0);
        chk("t6.ready", 64'(cmd_ready[0]), 64'd1);
        chk("t6.pkt_cnt", 64'(pkt_cnt[0]), 64'd0);
        chk("t6.flit_cnt", 64'(flit_cnt[0]), 64'd0);
        @(posedge clk); #1;
        rst_ = 1'b0;
        b = log0.size();
        send(4'h7, 4'h7, 2'd1, 4'd2, 22'h55);
        wait_log0(b + 1);
        f = log0[b];
        chk("t6.new_head_type", 64'(f[TYPE_LSB +: 3]), 64'(T_HEAD));

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            iack      = {2'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) != 0)} == 0 ?
                        2'b00 : {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            ilck      = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_dst   = 4'($urandom);
            cmd_src   = 4'($urandom);
            cmd_vch   = 2'($urandom_range(0, 3));
            cmd_len   = 4'($urandom_range(0, 15));
            cmd_spec  = ($urandom_range(0, 7) == 0) ? 22'h3FFFF8 : 22'($urandom);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        iack = 2'b11;
        ilck = 2'b00;
        wait_idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
